// File: rtl/ram_dp_pkg.sv
// Shared types and helpers for the ram_dp_bypass scratch RAM.
// The byte_merge helper is sized for the widest supported data path; callers cast in and out.
package ram_dp_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 4;

  // Upper bound on DATA_W accepted by byte_merge.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_data,
    input logic [MAX_DATA_W-1:0] new_data,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_data;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_dp_init_ctrl.sv
// Post-reset clear sequencer: walks every entry once in INIT, then parks in RUN.
// ready rises on the same edge that finishes clearing the last entry.
module ram_dp_init_ctrl
  import ram_dp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_nxt;

  // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      INIT: begin
        count_nxt = count + ADDR_W'(1);
        if (count == LAST_ADDR) begin
          state_nxt = RUN;
          count_nxt = '0;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    ready    = (state == RUN);
    clr_we   = (state == INIT);
    clr_addr = count;
  end

endmodule

// File: rtl/ram_dp_bypass.sv
// Dual-port scratch RAM: byte-enabled write port, registered read port with write-first override.
// Define RAM_DP_OUT_REG_EN to add a second output register stage (read latency 2).
module ram_dp_bypass
  import ram_dp_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DEPTH  = 1 << ADDR_W,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [BE_W-1:0]   write_be,
  input  logic              re,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              collision,
  output logic              ready
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  ram_dp_init_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_ctrl (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User traffic is only accepted once the clear has finished.
  logic wr_in_range;
  logic rd_in_range;
  logic user_wr;
  logic user_rd;
  logic collide_now;

  assign wr_in_range = ({1'b0, write_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, read_addr} < DEPTH_L);
  assign user_wr     = ready & we & wr_in_range;
  assign user_rd     = ready & re;
  assign collide_now = user_rd & user_wr & (read_addr == write_addr);

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [BE_W-1:0]   mem_be;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = write_addr;
    mem_data = write_data;
    mem_be   = write_be;
    if (clr_we) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
      mem_data = '0;
      mem_be   = '1;
    end else if (user_wr) begin
      mem_we   = 1'b1;
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; it is zeroed by the INIT sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_data[8*i +: 8];
      end
    end
  end

  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_next;

  assign rd_old  = rd_in_range ? mem[read_addr] : '0;
  assign rd_next = collide_now
                 ? DATA_W'(byte_merge(MAX_DATA_W'(rd_old), MAX_DATA_W'(write_data),
                                      MAX_BE_W'(write_be)))
                 : rd_old;

  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic              s1_coll;

  // Stage 1 holds its data between reads; valid and collision are single-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
    end else begin
      s1_valid <= user_rd;
      s1_coll  <= collide_now;
      if (user_rd) s1_data <= rd_next;
    end
  end

`ifdef RAM_DP_OUT_REG_EN
  logic [DATA_W-1:0] s2_data;
  logic              s2_valid;
  logic              s2_coll;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_data  <= '0;
      s2_valid <= 1'b0;
      s2_coll  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_coll  <= s1_coll;
      if (s1_valid) s2_data <= s1_data;
    end
  end

  assign read_data  = s2_data;
  assign read_valid = s2_valid;
  assign collision  = s2_coll;
`else
  assign read_data  = s1_data;
  assign read_valid = s1_valid;
  assign collision  = s1_coll;
`endif

endmodule

// File: tb/tb_ram_dp_bypass.sv
// Directed plus randomized bench for ram_dp_bypass against a behavioural memory model.
// Read latency follows RAM_DP_OUT_REG_EN.
module tb_ram_dp_bypass;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int BE_W   = 8;
`ifdef RAM_DP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              reset;
  logic              we;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [BE_W-1:0]   write_be;
  logic              re;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic              collision;
  logic              ready;

  ram_dp_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_be   (write_be),
    .re         (re),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_valid (read_valid),
    .collision  (collision),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct packed {
    logic              valid;
    logic              coll;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  rsp_t              hist [2];
  bit                ready_m;
  int                init_edges;
  logic [DATA_W-1:0] exp_data;
  logic              exp_valid;
  logic              exp_coll;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] mask;
    for (int i = 0; i < BE_W; i++) mask[8*i +: 8] = {8{be[i]}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic model_reset();
    ready_m    = 1'b0;
    init_edges = 0;
    hist[0]    = '0;
    hist[1]    = '0;
    exp_data   = '0;
    exp_valid  = 1'b0;
    exp_coll   = 1'b0;
  endtask

  // One rising edge of the reference: clear phase counts edges, then reads see old data or the merge.
  task automatic model_edge();
    rsp_t              rec;
    logic [DATA_W-1:0] old_v;
    if (!reset) return;
    rec = '0;
    if (!ready_m) begin
      init_edges++;
      if (init_edges == DEPTH) begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ready_m = 1'b1;
      end
    end else begin
      old_v = ref_mem[read_addr];
      if (re) begin
        rec.valid = 1'b1;
        rec.coll  = we && (write_addr == read_addr);
        rec.data  = rec.coll ? merge(old_v, write_data, write_be) : old_v;
      end
      if (we) ref_mem[write_addr] = merge(ref_mem[write_addr], write_data, write_be);
    end
    hist[1]   = hist[0];
    hist[0]   = rec;
    exp_valid = hist[LAT-1].valid;
    exp_coll  = hist[LAT-1].coll;
    if (exp_valid) exp_data = hist[LAT-1].data;
  endtask

  task automatic check_outputs(input string tag);
    checks++;
    assert (ready === ready_m) else begin
      failures++;
      $error("FAIL %s ready observed=%0b expected=%0b", tag, ready, ready_m);
    end
    checks++;
    assert (read_valid === exp_valid) else begin
      failures++;
      $error("FAIL %s read_valid observed=%0b expected=%0b", tag, read_valid, exp_valid);
    end
    checks++;
    assert (collision === exp_coll) else begin
      failures++;
      $error("FAIL %s collision observed=%0b expected=%0b", tag, collision, exp_coll);
    end
    checks++;
    assert (read_data === exp_data) else begin
      failures++;
      $error("FAIL %s read_data observed=%h expected=%h", tag, read_data, exp_data);
    end
  endtask

  task automatic expect_read(input string tag, input logic [DATA_W-1:0] data_req,
                             input logic coll_req);
    checks++;
    assert (read_valid === 1'b1 && read_data === data_req && collision === coll_req) else begin
      failures++;
      $error("FAIL %s observed valid=%0b coll=%0b data=%h expected valid=1 coll=%0b data=%h",
             tag, read_valid, collision, read_data, coll_req, data_req);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic drive_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [BE_W-1:0] be);
    we         = 1'b1;
    write_addr = a;
    write_data = d;
    write_be   = be;
  endtask

  task automatic drive_read(input logic [ADDR_W-1:0] a);
    re        = 1'b1;
    read_addr = a;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    we         = 1'b0;
    re         = 1'b0;
    write_addr = '0;
    write_data = '0;
    write_be   = '0;
    read_addr  = '0;
    model_reset();

    #1 check_outputs("in_reset");
    step("reset_hold0");
    step("reset_hold1");
    @(negedge clk) reset = 1'b1;

    // Traffic offered throughout the clear must be ignored.
    drive_write(4'd3, 64'hAA, 8'hFF);
    drive_read(4'd3);
    for (int i = 0; i < DEPTH; i++) step($sformatf("init_%0d", i));
    checks++;
    assert (ready === 1'b1) else begin
      failures++;
      $error("FAIL ready_after_clear observed=%0b expected=1", ready);
    end

    idle();
    for (int i = 0; i < DEPTH; i++) begin
      drive_read(ADDR_W'(i));
      step($sformatf("sweep_%0d", i));
    end
    idle();
    repeat (LAT) step("sweep_drain");

    // Write then read next cycle; result lands exactly LAT edges after the request.
    drive_write(4'd5, 64'd5, 8'hFF);
    step("wr5");
    idle();
    drive_read(4'd5);
    step("rd5_req");
    idle();
    repeat (LAT - 1) step("rd5_wait");
    expect_read("rd5_latency", 64'd5, 1'b0);
    step("rd5_after");

    // Write-first override with partial byte enables.
    drive_write(4'd7, 64'h1111_2222_3333_4444, 8'hFF);
    step("wr7");
    drive_write(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    drive_read(4'd7);
    step("ovr7_req");
    idle();
    repeat (LAT - 1) step("ovr7_wait");
    expect_read("ovr7_merge", 64'h1111_2222_FFFF_FFFF, 1'b1);
    drive_read(4'd7);
    step("rd7_req");
    idle();
    repeat (LAT - 1) step("rd7_wait");
    expect_read("rd7_follow", 64'h1111_2222_FFFF_FFFF, 1'b0);

    // Zero byte enable is a no-op.
    drive_write(4'd2, 64'hDEAD_BEEF_CAFE_F00D, 8'h00);
    step("wr2_be0");
    idle();
    drive_read(4'd2);
    step("rd2_req");
    idle();
    repeat (LAT - 1) step("rd2_wait");
    expect_read("rd2_unchanged", 64'd0, 1'b0);

    // Randomized traffic; read address often tracks the write address to force overrides.
    repeat (400) begin
      we         = 1'($urandom_range(0, 1));
      re         = 1'($urandom_range(0, 1));
      write_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      write_data = {$urandom, $urandom};
      write_be   = BE_W'($urandom);
      read_addr  = ($urandom_range(0, 2) == 0) ? write_addr : ADDR_W'($urandom);
      step("rand");
    end
    idle();
    repeat (LAT) step("rand_drain");

    // Reset while a read is in flight: outputs drop at once and the clear reruns.
    drive_read(4'd5);
    step("rst_req");
    #1 reset = 1'b0;
    model_reset();
    #1 check_outputs("rst_async");
    idle();
    step("rst_hold");
    reset = 1'b1;
    drive_write(4'd9, 64'h55, 8'hFF);
    drive_read(4'd5);
    for (int i = 0; i < DEPTH; i++) step($sformatf("reinit_%0d", i));
    idle();
    drive_read(4'd5);
    step("rd5_post_reset_req");
    idle();
    repeat (LAT - 1) step("rd5_post_reset_wait");
    expect_read("rd5_post_reset", 64'd0, 1'b0);
    step("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dp_bypass.md
Name: ram_dp_bypass

Overview:
- Parametrised successor to the 64x16 overriding dual-port RAM.
- One write port and one read port on one clock. Write port has byte enables.
- Read latency is one cycle, with a read_valid qualifier. A same-cycle, same-address read returns the newly written data (write-first override).
- Built-in sequential clear after reset. A ready flag gates all traffic until the clear finishes.
- Sits between datapath producers and consumers as a local scratch buffer.

Parameters:
- DATA_W, 64, data width in bits; must be a multiple of 8.
- ADDR_W, 4, address width.
- DEPTH, 1<<ADDR_W, number of entries; must be ≤ 2**ADDR_W.
- BE_W, DATA_W/8, byte-enable width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- write_be  in  BE_W  byte enables; bit i covers write_data[8i+7:8i].
- re  in  1  read enable.
- read_addr  in  ADDR_W  read address.
- read_data  out  DATA_W  read data.
- read_valid  out  1  read_data valid; one-cycle pulse per accepted read.
- collision  out  1  pulse: previous cycle had an accepted read and write to the same address.
- ready  out  1  high once the post-reset clear is complete.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=INIT, clear counter=0.
  - read_data=0, read_valid=0, collision=0, ready=0.
  - Memory contents are not touched by reset itself.
- INIT state:
  - Each cycle writes 0 to entry[counter], then counter+1.
  - After writing entry DEPTH-1, the next state is RUN and ready=1 on that same edge.
  - INIT therefore lasts DEPTH cycles.
  - we and re are ignored during INIT: no write, read_valid stays 0.
- RUN state: stays in RUN until reset.
- Write (RUN, we=1):
  - At the rising edge, entry[write_addr] byte i is updated only where write_be[i]=1.
  - write_be=0 is a no-op.
- Read (RUN, re=1):
  - read_data is registered and appears one edge later, with read_valid=1 for exactly that cycle.
  - When re=0: read_valid=0 and read_data holds its last value.
- Override (same cycle, re=1 & we=1 & read_addr==write_addr):
  - read_data = per-byte merge: write_data where write_be=1, old entry bytes elsewhere.
  - collision=1 in the same cycle as read_valid.
- Write in cycle N, read of the same address in cycle N+1: returns the new data (no special path needed).
- Out-of-range address (≥ DEPTH when DEPTH < 2**ADDR_W):
  - Write is dropped.
  - Read returns 0 with read_valid=1.
- Reset asserted mid-operation:
  - Outputs clear immediately.
  - Any pending read is lost.
  - Memory is re-cleared through INIT.

Optional Feature:
- Macro: RAM_DP_OUT_REG_EN.
- Defined:
  - Adds a second output register stage; read latency is 2.
  - read_valid and collision are delayed alongside the data.
  - Override merge is still computed at stage 1.
  - Back-to-back reads stream one result per cycle.
  - Reset clears both stages.
- Undefined: latency 1, as described above.

Decomposition:
- Package ram_dp_pkg:
  - state enum {INIT, RUN}.
  - Default DATA_W/ADDR_W constants.
  - Function byte_merge(old, new, be).
- Sub-module ram_dp_init_ctrl:
  - Contains the INIT/RUN FSM and clear counter.
  - Outputs: ready, clr_we, clr_addr.
- Top level: muxes clear vs user write, storage array, read/override pipeline.

Test Plan:
- Reset then idle: ready=0 for 16 cycles, ready=1 from cycle 16; every address then reads 0.
- Traffic during INIT: we=1 addr 3 data 0xAA, re=1 addr 3. Required: no write, read_valid=0. After ready, reading addr 3 returns 0.
- Write addr 5 data 64'd5 be=0xFF, next cycle read addr 5. Required: read_data=5 one cycle later, read_valid pulses once.
- Entry 7 holds 0x1111_2222_3333_4444. Same-cycle write to addr 7 with data 0xFFFF_FFFF_FFFF_FFFF, be=0x0F, plus read of addr 7. Required: read_data=0x1111_2222_FFFF_FFFF, collision=1. A following read returns the same value.
- Write addr 2 with be=0x00. Required: entry unchanged (reads 0 after clear).
- Assert reset for 1 cycle between a read request and its response. Required: read_valid stays 0, ready drops and the 16-cycle clear reruns. With RAM_DP_OUT_REG_EN defined, repeat the 64'd5 case and check latency is 2.
